fetch_unit: RTL and testbench

// - Instruction-fetch stage. Owns the PC and drives a variable-latency instruction-memory

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_pc_reg.sv | 43 ++++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          WORD_LEN    = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0;
    localparam int          INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Next-fetch PC register with +4 incrementer and word-aligned redirect mux.
module fetch_pc_reg #(
    parameter int                   WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                advance_i,
    input  logic                redirect_i,
    input  logic [WORD_LEN-1:0] redirect_addr_i,
    input  logic [WORD_LEN-1:0] base_i,
    output logic [WORD_LEN-1:0] pc_o,
    output logic [WORD_LEN-1:0] base_plus4_o,
    output logic [WORD_LEN-1:0] target_o
);
    import fetch_pkg::INSTR_BYTES;

    logic [WORD_LEN-1:0] pc_d;
    logic [WORD_LEN-1:0] pc_q;

    // Wraps modulo 2^WORD_LEN; a redirect target is forced word-aligned.
    assign base_plus4_o = base_i + WORD_LEN'(INSTR_BYTES);
    assign target_o     = redirect_addr_i & ~WORD_LEN'(INSTR_BYTES - 1);
    assign pc_o         = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_o;
        end else if (advance_i) begin
            pc_d = base_plus4_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a variable-latency imem port and
// feeds IF2ID with {PC+4, instruction}, inserting NOP bubbles when no word is ready.
module fetch_unit #(
    parameter int                   WORD_LEN  = fetch_pkg::WORD_LEN,
    parameter logic [WORD_LEN-1:0]  RESET_PC  = '0,
    parameter logic [WORD_LEN-1:0]  NOP_INSTR = WORD_LEN'(fetch_pkg::NOP_INSTR)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branchTaken,
    input  logic [WORD_LEN-1:0] branchAddr,
    output logic                imemReq,
    output logic [WORD_LEN-1:0] imemAddr,
    input  logic                imemReady,
    input  logic [WORD_LEN-1:0] imemRdata,
    output logic [WORD_LEN-1:0] PC,
    output logic [WORD_LEN-1:0] instruction,
    output logic                valid,
    output logic                fetchStall
);
    import fetch_pkg::fetch_state_t;
    import fetch_pkg::FETCH;
    import fetch_pkg::HOLD;
    import fetch_pkg::DRAIN;

    fetch_state_t        state_q, state_d;
    logic [WORD_LEN-1:0] req_addr_q, req_addr_d;
    logic [WORD_LEN-1:0] hold_instr_q, hold_instr_d;
    logic [WORD_LEN-1:0] hold_pc_q, hold_pc_d;
    logic                active_q;

    logic                pc_advance;
    logic                pc_redirect;
    logic [WORD_LEN-1:0] pc_reg;
    logic [WORD_LEN-1:0] req_plus4;
    logic [WORD_LEN-1:0] branch_target;

    fetch_pc_reg #(
        .WORD_LEN (WORD_LEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .advance_i       (pc_advance),
        .redirect_i      (pc_redirect),
        .redirect_addr_i (branchAddr),
        .base_i          (req_addr_q),
        .pc_o            (pc_reg),
        .base_plus4_o    (req_plus4),
        .target_o        (branch_target)
    );

    assign imemAddr   = req_addr_q;
    assign fetchStall = !valid;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        pc_advance   = 1'b0;
        pc_redirect  = 1'b0;
        imemReq      = 1'b0;
        valid        = 1'b0;
        instruction  = NOP_INSTR;
        PC           = '0;

        // The first request waits one cycle after reset release.
        if (active_q) begin
            unique case (state_q)
                FETCH: begin
                    imemReq = 1'b1;
                    if (imemReady && branchTaken) begin
                        pc_redirect = 1'b1;
                        req_addr_d  = branch_target;
                    end else if (imemReady) begin
                        valid       = 1'b1;
                        instruction = imemRdata;
                        PC          = req_plus4;
                        if (freeze) begin
                            hold_instr_d = imemRdata;
                            hold_pc_d    = req_plus4;
                            state_d      = HOLD;
                        end else begin
                            pc_advance = 1'b1;
                            req_addr_d = req_plus4;
                        end
                    end else if (branchTaken) begin
                        pc_redirect = 1'b1;
                        state_d     = DRAIN;
                    end
                end
                HOLD: begin
                    if (branchTaken) begin
                        pc_redirect = 1'b1;
                        req_addr_d  = branch_target;
                        state_d     = FETCH;
                    end else begin
                        valid       = 1'b1;
                        instruction = hold_instr_q;
                        PC          = hold_pc_q;
                        if (!freeze) begin
                            pc_advance = 1'b1;
                            req_addr_d = hold_pc_q;
                            state_d    = FETCH;
                        end
                    end
                end
                DRAIN: begin
                    // Old address stays on the bus until the stale response lands.
                    imemReq     = 1'b1;
                    pc_redirect = branchTaken;
                    if (imemReady) begin
                        req_addr_d = branchTaken ? branch_target : pc_reg;
                        state_d    = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FETCH;
            req_addr_q   <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
            hold_pc_q    <= '0;
            active_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            active_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a behavioural imem with programmable latency and a
// scoreboard that checks every word accepted by IF2ID arrives exactly once, in order.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic [31:0] imemRdata;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        valid;
    logic        fetchStall;

    int   checks = 0;
    int   errors = 0;
    int   lat    = 0;
    bit   mem_en = 1'b1;
    int   wait_cnt = 0;
    exp_t sb[$];

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branchTaken (branchTaken),
        .branchAddr  (branchAddr),
        .imemReq     (imemReq),
        .imemAddr    (imemAddr),
        .imemReady   (imemReady),
        .imemRdata   (imemRdata),
        .PC          (PC),
        .instruction (instruction),
        .valid       (valid),
        .fetchStall  (fetchStall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] addr);
        exp_t e;
        e.pc    = addr + 32'd4;
        e.instr = mem_word(addr);
        sb.push_back(e);
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Instruction memory: answers after `lat` waiting cycles while mem_en is set.
    initial begin
        imemReady = 1'b0;
        imemRdata = '0;
        forever begin
            @(negedge clk);
            if (imemReq && mem_en && wait_cnt >= lat) begin
                imemReady = 1'b1;
                imemRdata = mem_word(imemAddr);
                wait_cnt  = 0;
            end else if (imemReq) begin
                imemReady = 1'b0;
                imemRdata = '0;
                wait_cnt++;
            end else begin
                imemReady = 1'b0;
                imemRdata = '0;
                wait_cnt  = 0;
            end
        end
    end

    // IF2ID acceptance: a word is taken when valid and the stage is not frozen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (valid === 1'b1 && freeze === 1'b0) begin
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_pc", PC, e.pc);
                    check("sb_instr", instruction, e.instr);
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        freeze      = 1'b0;
        branchTaken = 1'b0;
        branchAddr  = '0;

        // Reset state
        #2;
        check("rst_req", 32'(imemReq), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_stall", 32'(fetchStall), 32'd1);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc", PC, 32'h0);

        // 1: zero-wait memory, back-to-back fetches
        for (int i = 0; i < 4; i++) push_exp(32'(4 * i));
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(); #1;
            check("t1_addr", imemAddr, 32'(4 * i));
            check("t1_valid", 32'(valid), 32'd1);
            check("t1_pc", PC, 32'(4 * i + 4));
        end

        // 2: three-cycle latency after a fresh reset
        step();
        lat = 3;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            check("t2_addr", imemAddr, 32'h0);
            check("t2_req", 32'(imemReq), 32'd1);
            check("t2_instr", instruction, 32'h0);
            check("t2_stall", 32'(fetchStall), 32'd1);
        end
        push_exp(32'h0);
        step(); #1;
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_pc", PC, 32'h4);
        lat = 0;

        // 3: freeze held two cycles on the word at address 8
        push_exp(32'h4);
        step(); #1;
        check("t3_pc4", PC, 32'h8);
        push_exp(32'h8);
        step(); freeze = 1'b1; #1;
        check("t3_cap_valid", 32'(valid), 32'd1);
        check("t3_cap_pc", PC, 32'hC);
        step(); #1;
        check("t3_hold_req", 32'(imemReq), 32'd0);
        check("t3_hold_pc", PC, 32'hC);
        check("t3_hold_instr", instruction, mem_word(32'h8));
        step(); freeze = 1'b0; #1;
        check("t3_rel_valid", 32'(valid), 32'd1);
        check("t3_rel_req", 32'(imemReq), 32'd0);
        check("t3_rel_pc", PC, 32'hC);
        push_exp(32'hC);
        step(); #1;
        check("t3_next_addr", imemAddr, 32'hC);
        check("t3_next_pc", PC, 32'h10);
        mem_en = 1'b0;

        // 4: redirect while address 16 is outstanding
        step(); branchTaken = 1'b1; branchAddr = 32'h103; #1;
        check("t4_addr", imemAddr, 32'h10);
        check("t4_valid", 32'(valid), 32'd0);
        step(); branchTaken = 1'b0; #1;
        check("t4_drain_req", 32'(imemReq), 32'd1);
        check("t4_drain_addr", imemAddr, 32'h10);
        check("t4_drain_valid", 32'(valid), 32'd0);
        mem_en = 1'b1;
        step(); #1;
        check("t4_late_ready", 32'(imemReady), 32'd1);
        check("t4_late_valid", 32'(valid), 32'd0);
        check("t4_late_addr", imemAddr, 32'h10);
        push_exp(32'h100);
        step(); #1;
        check("t4_new_addr", imemAddr, 32'h100);
        check("t4_new_pc", PC, 32'h104);

        // 5: branch together with ready and freeze
        step(); freeze = 1'b1; branchTaken = 1'b1; branchAddr = 32'h200; #1;
        check("t5_valid", 32'(valid), 32'd0);
        check("t5_instr", instruction, 32'h0);
        check("t5_stall", 32'(fetchStall), 32'd1);
        push_exp(32'h200);
        step(); freeze = 1'b0; branchTaken = 1'b0; #1;
        check("t5_req", 32'(imemReq), 32'd1);
        check("t5_addr", imemAddr, 32'h200);
        check("t5_pc", PC, 32'h204);

        // 6: address wrap, then reset while a request is waiting
        step(); branchTaken = 1'b1; branchAddr = 32'hFFFF_FFFC; #1;
        check("t6_br_valid", 32'(valid), 32'd0);
        push_exp(32'hFFFF_FFFC);
        step(); branchTaken = 1'b0; #1;
        check("t6_top_addr", imemAddr, 32'hFFFF_FFFC);
        check("t6_wrap_pc", PC, 32'h0);
        push_exp(32'h0);
        step(); #1;
        check("t6_wrap_addr", imemAddr, 32'h0);
        check("t6_wrap_pc4", PC, 32'h4);
        lat = 3;
        step(); #1;
        check("t6_wait_valid", 32'(valid), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_req", 32'(imemReq), 32'd0);
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_stall", 32'(fetchStall), 32'd1);
        check("t6_rst_pc", PC, 32'h0);
        check("t6_rst_addr", imemAddr, 32'h0);
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        #5;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
